// File: rtl/iob_native_resp_ram.sv
// iob_native_resp_ram: iob native responder over a word RAM with programmable response latency.
// Define IOB_RESP_RANGE_CHK_EN to add the sticky out-of-range err port.
module iob_native_resp_ram #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata
`ifdef IOB_RESP_RANGE_CHK_EN
  ,
  output logic                err
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  if (LAT < 1 || LAT > 15) begin : g_lat_chk
    $error("iob_native_resp_ram: LAT must be in 1..15");
  end
  if (DATA_W != 32) begin : g_dw_chk
    $error("iob_native_resp_ram: DATA_W must be 32");
  end
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  logic [DATA_W-1:0] word_q, word_d, rdata_q, rdata_d;
  logic rd_q, rd_d;
  logic accept, wr, oor;
  logic [MEM_ADDR_W-1:0] idx;
  assign idx = addr[MEM_ADDR_W+1:2];
  assign wr = |wstrb;
  assign accept = valid && (state_q == IDLE || state_q == RESP);
  assign ready = state_q == RESP;
  assign rdata = rdata_q;
`ifdef IOB_RESP_RANGE_CHK_EN
  logic oor_q, oor_d, err_q, err_d;
  logic unused_addr;
  assign unused_addr = ^addr[1:0];
  assign oor = |addr[ADDR_W-1:MEM_ADDR_W+2];
  assign err = err_q;
  always_comb begin
    oor_d = accept ? oor : oor_q;
    err_d = err_q | (state_d == RESP && oor_d);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
      err_q <= err_d;
    end
`else
  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:MEM_ADDR_W+2], addr[1:0]};
  assign oor = 1'b0;
`endif
  // Read data is captured at acceptance so later writes or input changes cannot disturb it.
  always_comb begin
    state_d = accept ? ((LAT == 1) ? RESP : WAIT)
            : (state_q == WAIT) ? ((cnt_q == 4'd1) ? RESP : WAIT) : IDLE;
    cnt_d = accept ? 4'(LAT - 1) : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
    rd_d = accept ? !wr : rd_q;
    word_d = accept ? (oor ? '0 : mem[idx]) : word_q;
    rdata_d = (state_d == RESP && rd_d) ? word_d : rdata_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= 1'b0;
      word_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      word_q <= word_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge clk)
    if (accept && wr && !oor && !rst)
      for (int b = 0; b < DATA_W/8; b++)
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule
